// File: rtl/sram_port_arb.sv
// Two-requester arbiter for the shared single-port config SRAM, with in-order read return.
// Define SRAM_ARB_FIXED_PRIO_EN for strict port-0 priority; default build is round-robin.
module sram_port_arb #(
   parameter int AW     = 16,
   parameter int DW     = 23,
   parameter int RD_LAT = 2
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          sram_cs,
   output logic          sram_wr,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_wdata,
   input  logic [DW-1:0] sram_rdata,
   output logic [2:0]    rd_pending
);
   localparam int NSTG = RD_LAT + 1;

   genvar gi;

   logic          last_gnt_reg;
   logic          gnt0, gnt1;
   logic          any_gnt, sel_port, sel_we, rd_issue;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Grants stay low while reset is asserted, even with requests pending.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (PRESETn) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
         gnt0 = m0_req;
         gnt1 = m1_req & ~m0_req;
`else
         if (m0_req && m1_req) begin
            gnt0 = last_gnt_reg;
            gnt1 = ~last_gnt_reg;
         end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
         end
`endif
      end
   end

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign any_gnt   = gnt0 | gnt1;
   assign sel_port  = gnt1;
   assign sel_we    = sel_port ? m1_we    : m0_we;
   assign sel_addr  = sel_port ? m1_addr  : m0_addr;
   assign sel_wdata = sel_port ? m1_wdata : m0_wdata;
   assign rd_issue  = any_gnt & ~sel_we;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         last_gnt_reg <= 1'b1;
      end else if (any_gnt) begin
         last_gnt_reg <= sel_port;
      end
   end

   logic          sram_cs_reg, sram_wr_reg;
   logic [AW-1:0] sram_addr_reg;
   logic [DW-1:0] sram_wdata_reg;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         sram_cs_reg    <= 1'b0;
         sram_wr_reg    <= 1'b0;
         sram_addr_reg  <= '0;
         sram_wdata_reg <= '0;
      end else begin
         sram_cs_reg <= any_gnt;
         sram_wr_reg <= any_gnt & sel_we;
         if (any_gnt) begin
            sram_addr_reg <= sel_addr;
         end
         if (any_gnt && sel_we) begin
            sram_wdata_reg <= sel_wdata;
         end
      end
   end

   assign sram_cs    = sram_cs_reg;
   assign sram_wr    = sram_wr_reg;
   assign sram_addr  = sram_addr_reg;
   assign sram_wdata = sram_wdata_reg;

   // Tag pipeline: the tail stage lines up with the cycle sram_rdata is valid.
   logic [NSTG-1:0] tag_valid_reg, tag_valid_next;
   logic [NSTG-1:0] tag_port_reg,  tag_port_next;
   logic            tail_valid, tail_port;

   assign tag_valid_next[0] = rd_issue;
   assign tag_port_next[0]  = sel_port;

   generate
      for (gi = 1; gi < NSTG; gi++) begin : g_tag
         assign tag_valid_next[gi] = tag_valid_reg[gi-1];
         assign tag_port_next[gi]  = tag_port_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         tag_valid_reg <= '0;
         tag_port_reg  <= '0;
      end else begin
         tag_valid_reg <= tag_valid_next;
         tag_port_reg  <= tag_port_next;
      end
   end

   assign tail_valid = tag_valid_reg[NSTG-1];
   assign tail_port  = tag_port_reg[NSTG-1];

   logic          m0_rvalid_reg, m1_rvalid_reg;
   logic [DW-1:0] m0_rdata_reg, m1_rdata_reg;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         m0_rvalid_reg <= 1'b0;
         m1_rvalid_reg <= 1'b0;
         m0_rdata_reg  <= '0;
         m1_rdata_reg  <= '0;
      end else begin
         m0_rvalid_reg <= tail_valid & ~tail_port;
         m1_rvalid_reg <= tail_valid & tail_port;
         if (tail_valid && !tail_port) begin
            m0_rdata_reg <= sram_rdata;
         end
         if (tail_valid && tail_port) begin
            m1_rdata_reg <= sram_rdata;
         end
      end
   end

   assign m0_rvalid = m0_rvalid_reg;
   assign m1_rvalid = m1_rvalid_reg;
   assign m0_rdata  = m0_rdata_reg;
   assign m1_rdata  = m1_rdata_reg;

   // Retire is counted on the edge that raises rvalid, so pending drops in the rvalid cycle.
   logic [2:0] rd_pending_reg, rd_pending_next;

   always_comb begin
      rd_pending_next = rd_pending_reg;
      case ({rd_issue, tail_valid})
         2'b10:   rd_pending_next = rd_pending_reg + 3'd1;
         2'b01:   rd_pending_next = rd_pending_reg - 3'd1;
         default: rd_pending_next = rd_pending_reg;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rd_pending_reg <= '0;
      end else begin
         rd_pending_reg <= rd_pending_next;
      end
   end

   assign rd_pending = rd_pending_reg;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed plus randomized bench for sram_port_arb against a queue-based response model.
// Build with +define+SRAM_ARB_FIXED_PRIO_EN to check the strict-priority variant.
module tb_sram_port_arb;
   localparam int AW     = 16;
   localparam int DW     = 23;
   localparam int RD_LAT = 2;
   localparam int MEMN   = 64;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          sram_cs, sram_wr;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata, sram_rdata;
   logic [2:0]    rd_pending;

   always #5 PCLK = ~PCLK;

   sram_port_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .sram_cs(sram_cs), .sram_wr(sram_wr), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .rd_pending(rd_pending)
   );

   function automatic logic [DW-1:0] init_val(input int i);
      return DW'(i * 32'h1F3D5 + 32'h2A);
   endfunction

   // SRAM macro model: read data appears RD_LAT cycles after the cs cycle began.
   logic          mem_init;
   logic [DW-1:0] sram_mem [MEMN];
   logic [DW-1:0] rd_pipe [RD_LAT];

   always @(posedge PCLK) begin
      if (mem_init) begin
         for (int i = 0; i < MEMN; i++) sram_mem[i] <= init_val(i);
      end else if (sram_cs && sram_wr) begin
         sram_mem[sram_addr[5:0]] <= sram_wdata;
      end
      rd_pipe[0] <= (sram_cs && !sram_wr) ? sram_mem[sram_addr[5:0]] : DW'($urandom);
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign sram_rdata = rd_pipe[RD_LAT-1];

   // Reference model state
   typedef struct {
      bit            port;
      logic [DW-1:0] data;
      int            due;
   } rsp_t;

   rsp_t          rq[$];
   logic [DW-1:0] shadow [MEMN];
   int            cyc;
   bit            lg_m;
   logic          e_cs, e_wr;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_rd0, e_rd1;
   bit            g0_seen, g1_seen;
   int            n_chk, n_pass, n_fail, max_pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rq.delete();
      lg_m    = 1'b1;
      e_cs    = 1'b0;
      e_wr    = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
      e_rd0   = '0;
      e_rd1   = '0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_m0_gnt", {31'd0, m0_gnt}, 0);
      chk("rst_m1_gnt", {31'd0, m1_gnt}, 0);
      chk("rst_cs", {31'd0, sram_cs}, 0);
      chk("rst_wr", {31'd0, sram_wr}, 0);
      chk("rst_addr", 32'(sram_addr), 0);
      chk("rst_wdata", 32'(sram_wdata), 0);
      chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
      chk("rst_m0_rdata", 32'(m0_rdata), 0);
      chk("rst_m1_rdata", 32'(m1_rdata), 0);
      chk("rst_pending", 32'(rd_pending), 0);
   endtask

   // Called at the falling edge of every cycle: compare, then advance the model.
   task automatic check_cycle();
      bit            eg0, eg1, ev0, ev1, p, we;
      bit            winner;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (PRESETn) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
         eg0 = m0_req;
         eg1 = m1_req && !m0_req;
`else
         winner = !lg_m;
         if (m0_req && m1_req) begin
            eg0 = (winner == 1'b0);
            eg1 = (winner == 1'b1);
         end else begin
            eg0 = m0_req;
            eg1 = m1_req;
         end
`endif
      end
      chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, eg0});
      chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, eg1});
      chk("sram_cs", {31'd0, sram_cs}, {31'd0, e_cs});
      chk("sram_wr", {31'd0, sram_wr}, {31'd0, e_wr});
      chk("sram_addr", 32'(sram_addr), 32'(e_addr));
      chk("sram_wdata", 32'(sram_wdata), 32'(e_wdata));

      ev0 = 1'b0;
      ev1 = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         if (rq[0].port) begin
            ev1   = 1'b1;
            e_rd1 = rq[0].data;
         end else begin
            ev0   = 1'b1;
            e_rd0 = rq[0].data;
         end
         $display("rsp cyc=%0d port%0d data=%h", cyc, rq[0].port, rq[0].data);
         void'(rq.pop_front());
      end
      chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, ev0});
      chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, ev1});
      chk("m0_rdata", 32'(m0_rdata), 32'(e_rd0));
      chk("m1_rdata", 32'(m1_rdata), 32'(e_rd1));
      chk("rd_pending", 32'(rd_pending), rq.size());
      if (int'(rd_pending) > max_pend) max_pend = int'(rd_pending);

      if (eg0 || eg1) begin
         p  = eg1;
         we = p ? m1_we : m0_we;
         a  = p ? m1_addr : m0_addr;
         wd = p ? m1_wdata : m0_wdata;
         e_cs   = 1'b1;
         e_wr   = we;
         e_addr = a;
         lg_m   = p;
         if (we) begin
            e_wdata = wd;
            shadow[a[5:0]] = wd;
            $display("txn cyc=%0d port%0d write addr=%h data=%h", cyc, p, a, wd);
         end else begin
            rq.push_back('{port: p, data: shadow[a[5:0]], due: cyc + RD_LAT + 2});
            $display("txn cyc=%0d port%0d read  addr=%h", cyc, p, a);
         end
      end else begin
         e_cs = 1'b0;
         e_wr = 1'b0;
      end
      g0_seen = m0_gnt;
      g1_seen = m1_gnt;
      cyc++;
   endtask

   task automatic tick();
      @(negedge PCLK);
      check_cycle();
      @(posedge PCLK);
      #1;
      if (g0_seen) m0_req = 1'b0;
      if (g1_seen) m1_req = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_req(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      if (!p) begin
         m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = wd;
      end else begin
         m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((m0_req || m1_req) && n < budget) begin
         tick();
         n++;
      end
      chk("grant_wait", {31'd0, m0_req | m1_req}, 0);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_fail = 0; max_pend = 0; cyc = 0;
      g0_seen = 1'b0; g1_seen = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
      for (int i = 0; i < MEMN; i++) shadow[i] = init_val(i);
      model_reset();
      mem_init = 1'b1;
      PRESETn  = 1'b1;
      #2;
      PRESETn  = 1'b0;

      // Reset: requests are ignored and all outputs sit at reset values
      set_req(0, 1'b0, 16'h0001, '0);
      set_req(1, 1'b1, 16'h0002, 23'h000055);
      #1;
      chk_reset_outputs();
      ticks(3);
      m0_req = 1'b0;
      m1_req = 1'b0;
      PRESETn  = 1'b1;
      mem_init = 1'b0;

      // Single write from port 0
      set_req(0, 1'b1, 16'h0012, 23'h7ABCDE);
      wait_idle(4);
      ticks(5);

      // Port 1 reads the value back
      set_req(1, 1'b0, 16'h0012, '0);
      wait_idle(4);
      ticks(6);

      // Both ports stream reads for six cycles
      max_pend = 0;
      for (int i = 0; i < 6; i++) begin
         if (!m0_req) set_req(0, 1'b0, AW'($urandom_range(0, MEMN-1)), '0);
         if (!m1_req) set_req(1, 1'b0, AW'($urandom_range(0, MEMN-1)), '0);
         tick();
      end
      wait_idle(10);
      ticks(6);
      chk("pend_peak", max_pend, RD_LAT + 1);

      // Two reads in flight, then reset pulse
      set_req(0, 1'b0, 16'h0003, '0);
      tick();
      set_req(1, 1'b0, 16'h0004, '0);
      tick();
      PRESETn = 1'b0;
      #1;
      chk_reset_outputs();
      model_reset();
      ticks(2);
      PRESETn = 1'b1;
      ticks(6);

      // Read then write to the same address, then read again
      set_req(0, 1'b0, 16'h0005, '0);
      tick();
      set_req(1, 1'b1, 16'h0005, 23'h000001);
      tick();
      set_req(0, 1'b0, 16'h0005, '0);
      wait_idle(4);
      ticks(6);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         if (!m0_req && $urandom_range(0, 2) != 0)
            set_req(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, MEMN-1)), DW'($urandom));
         if (!m1_req && $urandom_range(0, 2) != 0)
            set_req(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, MEMN-1)), DW'($urandom));
         tick();
      end
      wait_idle(10);
      ticks(8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
